// File: rtl/alpha_pixel_shifter.sv
// Alpha-pattern pixel shifter: fetches one pattern byte per character cell
// through a single-entry hold register, serialises it MSB first at the pixel
// rate, and drives the border level outside the active part of a line.
//
// Parameters
//   CHARS       characters per active line (1..255)
//   BORDER_LVL  pixel level driven outside active display
// Ports
//   Clk        in   single clock, all state changes on the rising edge
//   Reset      in   synchronous active-high reset
//   PixEn      in   one-cycle pixel-rate enable
//   LineStart  in   one-cycle pulse that begins (or restarts) an active line
//   AData      in   pattern byte, MSB = leftmost pixel
//   AValid     in   AData valid
//   AReq       out  combinational: shifter can accept a byte this cycle
//   Pixel      out  registered serial pixel
//   Active     out  registered: Pixel carries display data
//   Underrun   out  registered, sticky until Reset: a byte was late
module alpha_pixel_shifter #(
  parameter int unsigned CHARS      = 32,
  parameter logic        BORDER_LVL = 1'b0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       PixEn,
  input  logic       LineStart,
  input  logic [7:0] AData,
  input  logic       AValid,
  output logic       AReq,
  output logic       Pixel,
  output logic       Active,
  output logic       Underrun
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned BIT_W  = 3;

  localparam logic [CNT_W-1:0]  CHARS_C   = CNT_W'(CHARS);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] BORDER_BY = {DATA_W{BORDER_LVL}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_ACTIVE,
    S_DRAIN
  } state_e;

  state_e             state_q,     state_d;
  logic [DATA_W-1:0]  hold_q,      hold_d;
  logic               hold_full_q, hold_full_d;
  logic [DATA_W-1:0]  shift_q,     shift_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [CNT_W-1:0]   emit_cnt_q,  emit_cnt_d;
  logic               pixel_q,     pixel_d;
  logic               active_q,    active_d;
  logic               underrun_q,  underrun_d;

  logic               in_fetch_state_c;
  logic               xfer_c;
  logic [CNT_W-1:0]   emit_next_c;

  // Byte request: hold empty, line not fully fetched, and in a fetching state.
  assign in_fetch_state_c = (state_q == S_PRIME) || (state_q == S_ACTIVE);
  assign AReq             = !hold_full_q && (fetch_cnt_q < CHARS_C) && in_fetch_state_c;
  assign xfer_c           = AReq && AValid;
  assign emit_next_c      = emit_cnt_q + CNT_W'(1);

  assign Pixel    = pixel_q;
  assign Active   = active_q;
  assign Underrun = underrun_q;

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      fetch_cnt_q <= '0;
      emit_cnt_q  <= '0;
      pixel_q     <= BORDER_LVL;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      fetch_cnt_q <= fetch_cnt_d;
      emit_cnt_q  <= emit_cnt_d;
      pixel_q     <= pixel_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    fetch_cnt_d = fetch_cnt_q;
    emit_cnt_d  = emit_cnt_q;
    pixel_d     = pixel_q;
    active_d    = active_q;
    underrun_d  = underrun_q;

    // A handshake always lands in the hold register; the state logic below
    // only ever empties the hold when it was already full (no same-cycle
    // accept), so the two never collide.
    if (xfer_c) begin
      hold_d      = AData;
      hold_full_d = 1'b1;
      fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        pixel_d  = BORDER_LVL;
        active_d = 1'b0;
        if (LineStart) begin
          state_d     = S_PRIME;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
          fetch_cnt_d = '0;
          emit_cnt_d  = '0;
        end
      end

      S_PRIME, S_ACTIVE, S_DRAIN: begin
        if (LineStart) begin
          // Restart. A byte handed over in this same cycle was accepted by
          // the source's view of the handshake, so it becomes the first byte
          // of the new line rather than being silently dropped.
          state_d     = S_PRIME;
          hold_full_d = xfer_c;
          bit_cnt_d   = '0;
          fetch_cnt_d = CNT_W'(xfer_c);
          emit_cnt_d  = '0;
          pixel_d     = BORDER_LVL;
          active_d    = 1'b0;
        end else begin
          unique case (state_q)
            S_PRIME: begin
              // PixEn is ignored until the first byte reaches the shifter.
              if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
                bit_cnt_d   = '0;
                state_d     = S_ACTIVE;
              end
            end

            S_ACTIVE: begin
              if (PixEn) begin
                pixel_d   = shift_q[DATA_W-1];
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                active_d  = 1'b1;
                if (bit_cnt_q == LAST_BIT) begin
                  emit_cnt_d = emit_next_c;
                  if (emit_next_c == CHARS_C) begin
                    state_d = S_DRAIN;
                  end else if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                  end else begin
                    // Late byte: show a border-level cell and skip its fetch
                    // slot so later bytes stay aligned with their cells.
                    underrun_d  = 1'b1;
                    shift_d     = BORDER_BY;
                    fetch_cnt_d = fetch_cnt_d + CNT_W'(1);
                  end
                end
              end
            end

            S_DRAIN: begin
              // Last data pixel stays visible until the next pixel slot.
              if (PixEn) begin
                pixel_d  = BORDER_LVL;
                active_d = 1'b0;
                state_d  = S_IDLE;
              end
            end

            default: begin
              state_d = S_IDLE;
            end
          endcase
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alpha_pixel_shifter.sv
// Scoreboard bench for alpha_pixel_shifter: two instances (CHARS=2/border 0
// and CHARS=1/border 1). Each line's expected pixel stream is built from the
// byte list and the number of bytes the source supplies; a negedge monitor
// pops one expected pixel per displayed pixel slot.
module tb_alpha_pixel_shifter;

  localparam int unsigned NDUT = 2;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       reset_s    [NDUT];
  logic       pix_en     [NDUT];
  logic       line_start [NDUT];
  logic       avalid     [NDUT];
  logic [7:0] adata      [NDUT];
  logic       areq       [NDUT];
  logic       pixel      [NDUT];
  logic       active     [NDUT];
  logic       underrun   [NDUT];

  int   n_checks = 0;
  int   n_fails  = 0;
  bit   exp_q    [NDUT][$];
  logic exp_ur   [NDUT];
  int   pix_seen [NDUT];
  logic pe_prev  [NDUT];
  logic pix_prev [NDUT];
  logic [7:0] lb [4];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    alpha_pixel_shifter #(
      .CHARS      (g == 0 ? 2 : 1),
      .BORDER_LVL (g == 0 ? 1'b0 : 1'b1)
    ) u_dut (
      .Clk       (Clk),
      .Reset     (reset_s[g]),
      .PixEn     (pix_en[g]),
      .LineStart (line_start[g]),
      .AData     (adata[g]),
      .AValid    (avalid[g]),
      .AReq      (areq[g]),
      .Pixel     (pixel[g]),
      .Active    (active[g]),
      .Underrun  (underrun[g])
    );
  end

  function automatic int chars_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic border_of(input int d);
    return (d == 0) ? 1'b0 : 1'b1;
  endfunction

  function automatic void check(input string name, input int d,
                                input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, got, exp, $time);
    end
  endfunction

  // Reference: supplied bytes MSB first, every missing byte shown as a
  // border-level cell, underrun whenever fewer bytes than cells arrive.
  function automatic void push_line(input int d, input int k);
    for (int c = 0; c < chars_of(d); c++)
      for (int b = 7; b >= 0; b--)
        exp_q[d].push_back((c < k) ? lb[c][b] : border_of(d));
    if (k < chars_of(d)) exp_ur[d] = 1'b1;
  endfunction

  // Monitor: one expected pixel per PixEn slot that shows display data;
  // otherwise the pixel must hold (active) or sit at border level.
  always @(negedge Clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (active[d] === 1'b1 && pe_prev[d] === 1'b1) begin
        pix_seen[d]++;
        check("pixel_expected", d, 32'(exp_q[d].size() != 0), 32'd1);
        if (exp_q[d].size() != 0) begin
          check("pixel_data", d, 32'(pixel[d]), 32'(exp_q[d].pop_front()));
        end
      end else if (active[d] === 1'b1) begin
        check("pixel_hold", d, 32'(pixel[d]), 32'(pix_prev[d]));
      end else begin
        check("pixel_border", d, 32'(pixel[d]), 32'(border_of(d)));
      end
      pe_prev[d]  = pix_en[d];
      pix_prev[d] = pixel[d];
    end
  end

  function automatic logic next_pe(input int pmode, input int pcnt);
    if (pmode == 0) return 1'b1;
    if (pmode == 1) return 1'($urandom_range(0, 1));
    return (pcnt % 4 == 0);
  endfunction

  // One line: k bytes supplied from lb[], pixel enable pattern pmode
  // (0 every cycle, 1 random, 2 every 4th). brk_kind 1 restarts with
  // LineStart and 2 resets, after brk_after displayed pixels.
  task automatic run_line(input int d, input int k, input int pmode,
                          input int brk_after, input int brk_kind);
    int idx = 0, xfers = 0, pcnt = 0, base, kk, bk;
    bit seen = 0, done = 0, took;
    kk = k;
    bk = brk_kind;
    base = pix_seen[d];
    push_line(d, kk);
    line_start[d] = 1'b1;
    avalid[d]     = 1'b0;
    pix_en[d]     = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge Clk);
      took = areq[d] && avalid[d];
      @(posedge Clk);
      #1;
      if (took) begin
        idx++;
        xfers++;
      end
      line_start[d] = 1'b0;
      if (active[d]) seen = 1;
      else if (seen) done = 1;
      if (!done && bk != 0 && (pix_seen[d] - base) >= brk_after) begin
        avalid[d] = 1'b0;
        if (bk == 1) line_start[d] = 1'b1;
        else reset_s[d] = 1'b1;
        @(posedge Clk);
        #1;
        line_start[d] = 1'b0;
        reset_s[d]    = 1'b0;
        exp_q[d].delete();
        check("break_active", d, 32'(active[d]), 32'd0);
        check("break_pixel", d, 32'(pixel[d]), 32'(border_of(d)));
        if (bk == 1) begin
          check("restart_areq", d, 32'(areq[d]), 32'd1);
          for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
          kk = chars_of(d);
          push_line(d, kk);
          idx = 0;
          xfers = 0;
          seen = 0;
          bk = 0;
        end else begin
          exp_ur[d] = 1'b0;
          check("reset_areq", d, 32'(areq[d]), 32'd0);
          check("reset_underrun", d, 32'(underrun[d]), 32'd0);
          pix_en[d] = 1'b0;
          return;
        end
      end
      avalid[d] = !done && (idx < kk);
      adata[d]  = lb[idx[1:0]];
      pcnt++;
      pix_en[d] = next_pe(pmode, pcnt);
    end
    avalid[d] = 1'b0;
    pix_en[d] = 1'b0;
    check("line_done", d, 32'(done), 32'd1);
    check("transfers", d, 32'(xfers), 32'(kk));
    check("queue_drained", d, 32'(exp_q[d].size()), 32'd0);
    check("underrun", d, 32'(underrun[d]), 32'(exp_ur[d]));
  endtask

  task automatic idle(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
      pix_en[d] = 1'($urandom_range(0, 1));
    end
    pix_en[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      reset_s[d]    = 1'b1;
      pix_en[d]     = 1'b1;
      line_start[d] = 1'b1;
      avalid[d]     = 1'b1;
      adata[d]      = 8'hFF;
      exp_ur[d]     = 1'b0;
      pix_seen[d]   = 0;
      pe_prev[d]    = 1'b0;
      pix_prev[d]   = 1'b0;
    end
    repeat (3) @(posedge Clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      check("rst_pixel", d, 32'(pixel[d]), 32'(border_of(d)));
      check("rst_active", d, 32'(active[d]), 32'd0);
      check("rst_areq", d, 32'(areq[d]), 32'd0);
      check("rst_underrun", d, 32'(underrun[d]), 32'd0);
      reset_s[d]    = 1'b0;
      pix_en[d]     = 1'b0;
      line_start[d] = 1'b0;
      avalid[d]     = 1'b0;
    end
    idle(0, 3);

    // Two full bytes, pixel enable every cycle.
    lb[0] = 8'hA5; lb[1] = 8'h3C;
    run_line(0, 2, 0, 0, 0);
    idle(0, 4);
    // Second byte withheld: border cell and sticky underrun.
    lb[0] = 8'hFF; lb[1] = 8'h00;
    run_line(0, 1, 0, 0, 0);
    idle(0, 4);
    // Slow pixel rate, every 4th cycle.
    lb[0] = 8'h81; lb[1] = 8'h81;
    run_line(0, 2, 2, 0, 0);
    idle(0, 4);
    // Restart after 5 pixels.
    lb[0] = 8'hC3; lb[1] = 8'h5A;
    run_line(0, 2, 0, 5, 1);
    idle(0, 4);
    // Reset in mid-line while underrun is set.
    lb[0] = 8'h96; lb[1] = 8'h69;
    run_line(0, 2, 1, 7, 2);
    idle(0, 4);
    // Border level 1, single zero byte.
    lb[0] = 8'h00;
    run_line(1, 1, 0, 0, 0);
    idle(1, 4);

    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      run_line(0, $urandom_range(1, 2), $urandom_range(0, 2), 0, 0);
      idle(0, $urandom_range(0, 5));
    end
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) lb[i] = 8'($urandom);
      run_line(1, 1, $urandom_range(0, 2), 0, 0);
      idle(1, $urandom_range(0, 5));
    end
    idle(0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
